// File: rtl/dense_pkg.sv
// dense_pkg: shared types, default parameters and helpers for dense_mac_array.
//   state_e    pass-sequencing FSM states
//   Def*       default parameter values for the top level
//   saturate() clamps a signed value to a signed range of the given width
package dense_pkg;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefFracW = 24;
    localparam int unsigned DefLanes = 4;
    localparam int unsigned DefLenW  = 16;

    // Widest lane word the saturation helper handles; DATA_W must stay below this.
    localparam int unsigned MaxW = 64;

    typedef enum logic [2:0] {
        StIdle,
        StAct,
        StWeight,
        StBias,
        StDone
    } state_e;

    // Clamp val to [-2^(width-1), 2^(width-1)-1]; result is sign-correct in the low width bits.
    function automatic logic signed [MaxW-1:0] saturate(input logic signed [2*MaxW-1:0] val,
                                                        input int unsigned width);
        logic signed [2*MaxW-1:0] one;
        logic signed [2*MaxW-1:0] hi;
        logic signed [2*MaxW-1:0] lo;
        one    = '0;
        one[0] = 1'b1;
        hi     = (one <<< (width - 1)) - one;
        lo     = ~hi;
        if (val > hi) begin
            return hi[MaxW-1:0];
        end else if (val < lo) begin
            return lo[MaxW-1:0];
        end else begin
            return val[MaxW-1:0];
        end
    endfunction

endpackage

// File: rtl/dense_lane.sv
// dense_lane: one output neuron of the dense accelerator.
// Holds a 2*DATA_W signed accumulator and a registered, saturated result.
// Optional feature: DENSE_RELU_EN clamps negative saturated results to 0 at the output
// register only; the accumulator keeps its signed value.
//   clk_i, reset_i  clock, asynchronous active-high reset
//   clear_i         zero the accumulator (start of pass)
//   mac_en_i        acc += (act_i * data_i) >>> FRAC_W
//   bias_en_i       acc += sign-extended data_i
//   load_i          capture the saturated next accumulator value into result_o
//   act_i, data_i   latched activation and incoming weight/bias word
//   result_o        registered lane result
module dense_lane
    import dense_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned FRAC_W = DefFracW
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              mac_en_i,
    input  logic              bias_en_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] act_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] result_o
);

    logic signed [2*DATA_W-1:0] acc_q, acc_d;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [2*MaxW-1:0]   acc_ext;
    logic signed [MaxW-1:0]     sat_full;
    logic        [DATA_W-1:0]   res_d, res_q;
    logic                       unused_sat_hi;

    always_comb begin
        // Operands widen to 2*DATA_W before multiplying, giving the full signed product.
        prod  = $signed(act_i) * $signed(data_i);
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (mac_en_i) begin
            acc_d = acc_q + (prod >>> FRAC_W);
        end else if (bias_en_i) begin
            acc_d = acc_q + $signed({{DATA_W{data_i[DATA_W-1]}}, data_i});
        end
        acc_ext  = {{(2*MaxW-2*DATA_W){acc_d[2*DATA_W-1]}}, acc_d};
        // Saturate the next value so the result is ready on the edge that takes the last bias.
        sat_full = saturate(acc_ext, DATA_W);
        res_d    = sat_full[DATA_W-1:0];
`ifdef DENSE_RELU_EN
        if (res_d[DATA_W-1]) begin
            res_d = '0;
        end
`endif
    end

    assign unused_sat_hi = ^sat_full[MaxW-1:DATA_W];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc_q <= '0;
            res_q <= '0;
        end else begin
            acc_q <= acc_d;
            if (load_i) begin
                res_q <= res_d;
            end
        end
    end

    assign result_o = res_q;

endmodule

// File: rtl/dense_mac_array.sv
// dense_mac_array: LANES-wide fixed-point dense-layer accelerator.
// Per pass consumes, for each of length activations, the activation then LANES weights,
// followed by LANES biases; then presents LANES saturated results.
// Optional feature: DENSE_RELU_EN (see dense_lane) clamps negative results to 0.
//   clk_i, reset_i          clock, asynchronous active-high reset
//   start_i, length_i       begin a pass (sampled in IDLE) with length activations
//   in_data_i/valid/ready   input word stream
//   out_data_o/valid/ready  result handshake; lane k at [k*DATA_W +: DATA_W]
//   busy_o                  high whenever not IDLE
module dense_mac_array
    import dense_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned FRAC_W = DefFracW,
    parameter int unsigned LANES  = DefLanes,
    parameter int unsigned LEN_W  = DefLenW
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic [LEN_W-1:0]        length_i,
    input  logic [DATA_W-1:0]       in_data_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [LANES*DATA_W-1:0] out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    busy_o
);

    localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;
    typedef logic [LaneW-1:0] lane_t;
    localparam lane_t LastLane = lane_t'(LANES - 1);

    state_e            state_q;
    logic [DATA_W-1:0] act_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  act_cnt_q;
    lane_t             lane_cnt_q;
    logic              in_ready_q, out_valid_q, busy_q;

    logic xfer, last_lane, last_act, clear, load;

    assign xfer      = in_valid_i && in_ready_q;
    assign last_lane = (lane_cnt_q == LastLane);
    // Extra bit keeps the compare correct when len_q is all ones.
    assign last_act  = (({1'b0, act_cnt_q} + 1'b1) == {1'b0, len_q});
    assign clear     = (state_q == StIdle) && start_i;
    assign load      = (state_q == StBias) && xfer && last_lane;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            act_q       <= '0;
            len_q       <= '0;
            act_cnt_q   <= '0;
            lane_cnt_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        len_q      <= length_i;
                        act_cnt_q  <= '0;
                        lane_cnt_q <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= (length_i == '0) ? StBias : StAct;
                    end
                end
                StAct: begin
                    if (xfer) begin
                        act_q      <= in_data_i;
                        lane_cnt_q <= '0;
                        state_q    <= StWeight;
                    end
                end
                StWeight: begin
                    if (xfer) begin
                        if (last_lane) begin
                            lane_cnt_q <= '0;
                            act_cnt_q  <= act_cnt_q + 1'b1;
                            state_q    <= last_act ? StBias : StAct;
                        end else begin
                            lane_cnt_q <= lane_cnt_q + 1'b1;
                        end
                    end
                end
                StBias: begin
                    if (xfer) begin
                        if (last_lane) begin
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            lane_cnt_q <= lane_cnt_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic mac_en, bias_en;
        assign mac_en  = (state_q == StWeight) && xfer && (lane_cnt_q == lane_t'(k));
        assign bias_en = (state_q == StBias) && xfer && (lane_cnt_q == lane_t'(k));

        dense_lane #(
            .DATA_W(DATA_W),
            .FRAC_W(FRAC_W)
        ) u_lane (
            .clk_i    (clk_i),
            .reset_i  (reset_i),
            .clear_i  (clear),
            .mac_en_i (mac_en),
            .bias_en_i(bias_en),
            .load_i   (load),
            .act_i    (act_q),
            .data_i   (in_data_i),
            .result_o (out_data_o[k*DATA_W +: DATA_W])
        );
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_dense_mac_array.sv
// Self-checking bench for dense_mac_array with LANES=2, Q8.24 words.
module tb_dense_mac_array;

    localparam int DW    = 32;
    localparam int LANES = 2;
    localparam int LW    = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [LW-1:0]       length;
    logic [DW-1:0]       in_data;
    logic                in_valid;
    logic                in_ready;
    logic [LANES*DW-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                busy;

    int n_checks = 0;
    int n_fails  = 0;
    int xfer_cnt = 0;

    logic [LANES*DW-1:0] exp_q[$];

    dense_mac_array #(
        .DATA_W(DW),
        .FRAC_W(24),
        .LANES (LANES),
        .LEN_W (LW)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .length_i   (length),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .out_data_o (out_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_valid && in_ready) xfer_cnt <= xfer_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] sat_lane(input longint a);
        longint        hi = 64'sd2147483647;
        longint        lo = -64'sd2147483648;
        logic   [DW-1:0] r;
        if (a > hi) r = 32'h7FFF_FFFF;
        else if (a < lo) r = 32'h8000_0000;
        else r = a[DW-1:0];
`ifdef DENSE_RELU_EN
        if (r[DW-1]) r = '0;
`endif
        return r;
    endfunction

    task automatic send(input logic [DW-1:0] d, input bit stall);
        int guard = 0;
        if (stall) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard == 50) check("in_ready_wait", 64'(in_ready), 64'd1);
        @(negedge clk);
    endtask

    task automatic run_pass(input int len, input logic [DW-1:0] acts[$],
                            input logic [DW-1:0] wts[$], input logic [DW-1:0] bias[$],
                            input bit stall);
        longint              acc[LANES];
        logic [LANES*DW-1:0] exp;
        for (int k = 0; k < LANES; k++) begin
            acc[k] = 0;
            for (int i = 0; i < len; i++) begin
                acc[k] += (longint'($signed(acts[i])) * longint'($signed(wts[i*LANES+k])))
                          >>> 24;
            end
            acc[k] += longint'($signed(bias[k]));
            exp[k*DW +: DW] = sat_lane(acc[k]);
        end
        exp_q.push_back(exp);
        start  = 1'b1;
        length = len[LW-1:0];
        @(negedge clk);
        start  = 1'b0;
        length = 16'hBEEF;  // must be ignored once the pass is running
        for (int i = 0; i < len; i++) begin
            send(acts[i], stall);
            for (int k = 0; k < LANES; k++) send(wts[i*LANES+k], stall);
        end
        for (int k = 0; k < LANES; k++) send(bias[k], stall);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic get_result(input string tag, input int hold);
        int                  guard = 0;
        logic [LANES*DW-1:0] exp;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_latency"}, 64'(guard), 64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        exp = exp_q.pop_front();
        check({tag, "_data"}, out_data, exp);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            @(negedge clk);
            check({tag, "_bp_in_ready"}, 64'(in_ready), 64'd0);
            check({tag, "_bp_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_bp_data"}, out_data, exp);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check({tag, "_valid_low"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [DW-1:0]       a_q[$];
        logic [DW-1:0]       w_q[$];
        logic [DW-1:0]       b_q[$];
        logic [LANES*DW-1:0] basic_exp;
        logic [LANES*DW-1:0] sat_exp;
        int                  base;

`ifdef DENSE_RELU_EN
        basic_exp = {32'h0000_0000, 32'h0340_0000};
        sat_exp   = {32'h0000_0000, 32'h7FFF_FFFF};
`else
        basic_exp = {32'hFF00_0000, 32'h0340_0000};
        sat_exp   = {32'h8000_0000, 32'h7FFF_FFFF};
`endif

        reset     = 1'b1;
        start     = 1'b0;
        length    = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic pass
        a_q = '{32'h0200_0000};
        w_q = '{32'h0180_0000, 32'hFF80_0000};
        b_q = '{32'h0040_0000, 32'h0000_0000};
        run_pass(1, a_q, w_q, b_q, 1'b0);
        get_result("basic", 0);
        check("basic_const", out_data, basic_exp);

        // Saturation, positive on lane 0 and negative on lane 1
        a_q = '{32'h7F00_0000};
        w_q = '{32'h7F00_0000, 32'h8100_0000};
        b_q = '{32'h0000_0000, 32'h0000_0000};
        run_pass(1, a_q, w_q, b_q, 1'b0);
        get_result("sat", 0);
        check("sat_const", out_data, sat_exp);

        // length==0 with backpressure on the result
        a_q.delete();
        w_q.delete();
        b_q  = '{32'h0010_0000, 32'hFFF0_0000};
        base = xfer_cnt;
        run_pass(0, a_q, w_q, b_q, 1'b0);
        get_result("len0", 5);
        check("len0_words", 64'(xfer_cnt - base), 64'd2);

        // Same length-3 data unstalled and stalled
        a_q = '{32'h0100_0000, 32'hFF00_0000, 32'h0080_0000};
        w_q = '{32'h0200_0000, 32'h0300_0000, 32'h0040_0000, 32'hFE00_0000,
                32'h0400_0000, 32'hFFC0_0000};
        b_q = '{32'h0001_0000, 32'hFFFF_0000};
        run_pass(3, a_q, w_q, b_q, 1'b0);
        get_result("nostall", 0);
        run_pass(3, a_q, w_q, b_q, 1'b1);
        get_result("stall", 0);

        // Random operands
        a_q.delete();
        w_q.delete();
        for (int i = 0; i < 4; i++) begin
            a_q.push_back($urandom);
            for (int k = 0; k < LANES; k++) w_q.push_back($urandom);
        end
        b_q = '{$urandom, $urandom};
        run_pass(4, a_q, w_q, b_q, 1'b0);
        get_result("random", 0);

        // Reset during WEIGHT, then a clean pass
        start  = 1'b1;
        length = 16'd2;
        @(negedge clk);
        start = 1'b0;
        send(32'h7F00_0000, 1'b0);
        send(32'h7F00_0000, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_out_data", out_data, 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        a_q = '{32'h0200_0000};
        w_q = '{32'h0180_0000, 32'hFF80_0000};
        b_q = '{32'h0040_0000, 32'h0000_0000};
        run_pass(1, a_q, w_q, b_q, 1'b0);
        get_result("postrst", 0);
        check("postrst_const", out_data, basic_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/dense_mac_array.md
# dense_mac_array

Parametrised multi-lane fixed-point dense-layer accelerator, the successor to the single-neuron dense MAC. It computes LANES output neurons in parallel from one shared activation stream: sum(act_i * w_i,lane) + bias_lane, with saturation to DATA_W. It sits between the processor-side stream bridge and the result readback registers, and uses valid/ready handshakes on both sides instead of a bare strobe.

## Interface
- DATA_W, 32: signed fixed-point word width.
- FRAC_W, 24: fractional bits (Q(DATA_W-FRAC_W).FRAC_W).
- LANES, 4: output neurons computed per pass; must be at least 1.
- LEN_W, 16: width of the length field.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a pass; sampled only in IDLE.
- length  in  LEN_W  number of activations in the pass; sampled with start.
- in_data  in  DATA_W  activation, weight or bias word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  LANES*DATA_W  results; lane k is at bits [k*DATA_W +: DATA_W].
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  high in every state except IDLE.

## Operation
- A word transfers when in_valid && in_ready. A result transfers when out_valid && out_ready.
- Input word order per pass: for each of length activations, one activation followed by LANES weights (lane 0 first). After the last activation group, LANES biases (lane 0 first).
- States:
  - IDLE
    - start moves to ACT, or to BIAS if length==0.
    - On start, all accumulators clear, len_reg<=length and act_cnt<=0.
  - ACT
    - A transfer latches act_reg and moves to WEIGHT with lane_cnt<=0.
  - WEIGHT
    - A transfer does acc[lane_cnt] += (act_reg*in_data)>>>FRAC_W.
    - On lane_cnt==LANES-1: act_cnt++. Go to BIAS if act_cnt+1==len_reg, otherwise go to ACT.
  - BIAS
    - A transfer does acc[lane_cnt] += sign-extended in_data.
    - On lane_cnt==LANES-1, go to DONE.
  - DONE
    - out_valid=1. An out_ready transfer returns to IDLE.
- Arithmetic:
  - The product is signed, 2*DATA_W bits. The shift is arithmetic (floor), with no rounding.
  - Accumulators are signed, 2*DATA_W bits.
  - out_data lane = acc saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- in_ready is high in ACT, WEIGHT and BIAS, and low in IDLE and DONE.
- start is ignored outside IDLE. Changes to length after start have no effect.
- Gaps in in_valid stall the FSM with no state change.

## Timing
- Reset values:
  - state=IDLE; in_ready=0, out_valid=0, busy=0.
  - out_data=0; all accumulators and counters are 0.
- A reset assertion mid-pass aborts immediately. The partial result is discarded and no out_valid is produced.
- Throughput is one input word per cycle with no bubbles between ACT, WEIGHT and BIAS.
- out_valid rises on the clock edge after the last bias transfer, so latency is 1 cycle.
- out_data is registered and held stable while out_valid && !out_ready.
- busy falls in the cycle after the output transfer. start may then be asserted in that IDLE cycle.
- When start and length==0 arrive together, only LANES bias words are consumed, and out = saturate(bias).

## Configuration
- DENSE_RELU_EN defined: each saturated lane result below 0 is output as 0; the accumulator itself is unchanged.
- DENSE_RELU_EN undefined: signed saturated results are output unmodified.

## Structure
- Package dense_pkg holds:
  - the state enum (IDLE, ACT, WEIGHT, BIAS, DONE);
  - default parameter constants;
  - a saturation function parametrised by width.
- Sub-module dense_lane holds one accumulator with clear, mac_en and bias_en controls, plus the saturation/ReLU output stage. It is instantiated LANES times in a generate loop.
- The top level holds the FSM, act_reg, counters and the handshake logic.

## Test plan
- Basic pass:
  - Stimulus: LANES=2, length=1, act=0x02000000, weights 0x01800000 and 0xFF800000, biases 0x00400000 and 0.
  - Response: lane0=0x03400000, lane1=0xFF000000.
  - With DENSE_RELU_EN: lane1=0.
- Saturation:
  - Stimulus: act=0x7F000000, weight=0x7F000000, bias=0.
  - Response: lane=0x7FFFFFFF.
  - With negated weight: lane=0x80000000.
- length=0:
  - Stimulus: biases 0x00100000 and 0xFFF00000.
  - Response: outputs equal the biases; exactly 2 words consumed.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles with in_valid=1.
  - Response: in_ready=0, out_data stable, out_valid=1 throughout; IDLE one cycle after out_ready=1.
- Input stalls:
  - Stimulus: toggle in_valid every other cycle for length=3.
  - Response: result identical to the unstalled run.
- Reset mid-pass:
  - Stimulus: assert reset during WEIGHT.
  - Response: all outputs 0 immediately. The next clean pass gives correct results with no leftover accumulator contribution.
